// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_if
// Brief    : Pipeline-side and memory-side signal bundle for mem_access_ctrl.
// Revision : 1.0
// ============================================================================
interface mem_access_ctrl_if;
  logic        d_req;
  logic        d_we;
  logic        d_wide;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_stall;

  logic        f_req;
  logic [31:0] f_addr;
  logic [15:0] f_rdata;
  logic        f_done;
  logic        f_stall;

  logic [31:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_mr;
  logic        m_mw;

  modport slave (
    input  d_req, d_we, d_wide, d_addr, d_wdata, f_req, f_addr, m_rdata,
    output d_rdata, d_done, d_stall, f_rdata, f_done, f_stall,
    output m_addr, m_wdata, m_mr, m_mw
  );

  modport master (
    output d_req, d_we, d_wide, d_addr, d_wdata, f_req, f_addr, m_rdata,
    input  d_rdata, d_done, d_stall, f_rdata, f_done, f_stall,
    input  m_addr, m_wdata, m_mr, m_mw
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Shares a single-port 16-bit memory between fetch and data ports,
//            splitting 32-bit accesses into two wait-stretched beats.
// Revision : 1.0
// ============================================================================
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] c_wc_last = 2'(WAIT_CYCLES - 1);

  state_t      r_state, w_state_n;
  logic [1:0]  r_wc, w_wc_n;
  logic [1:0]  r_sc, w_sc_n;
  logic        r_own_f, w_own_f_n;
  logic        r_we, w_we_n;
  logic        r_wide, w_wide_n;
  logic [31:0] r_addr, w_addr_n;
  logic [31:0] r_wdata, w_wdata_n;
  logic [31:0] r_res, w_res_n;

  logic [31:0] r_m_addr, w_m_addr_n;
  logic [15:0] r_m_wdata, w_m_wdata_n;
  logic        r_m_mr, w_m_mr_n;
  logic        r_m_mw, w_m_mw_n;
  logic        r_d_done, w_d_done_n;
  logic        r_f_done, w_f_done_n;
  logic [31:0] r_d_rdata, w_d_rdata_n;
  logic [15:0] r_f_rdata, w_f_rdata_n;

  logic        w_gnt_f;
  logic        w_gnt_d;

  // Fetch only wins a tie once data has been granted three times over it.
  assign w_gnt_f = bus.f_req & (~bus.d_req | (r_sc == 2'd3));
  assign w_gnt_d = bus.d_req & ~w_gnt_f;

  always_comb begin
    w_state_n = r_state;
    w_wc_n    = r_wc;
    w_sc_n    = r_sc;
    w_own_f_n = r_own_f;
    w_we_n    = r_we;
    w_wide_n  = r_wide;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_res_n   = r_res;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_f || !bus.f_req) begin
          w_sc_n = 2'd0;
        end else if (w_gnt_d) begin
          w_sc_n = r_sc + 2'd1;
        end
        if (w_gnt_f || w_gnt_d) begin
          w_state_n = S_BEAT0;
          w_wc_n    = 2'd0;
          w_own_f_n = w_gnt_f;
          w_we_n    = w_gnt_d & bus.d_we;
          w_wide_n  = w_gnt_d & bus.d_wide;
          w_addr_n  = w_gnt_f ? bus.f_addr : bus.d_addr;
          w_wdata_n = w_gnt_f ? 32'h0 : bus.d_wdata;
          w_res_n   = 32'h0;
        end
      end
      S_BEAT0, S_BEAT1: begin
        if (r_wc == c_wc_last) begin
          w_wc_n = 2'd0;
          if (!r_we) begin
            if (r_state == S_BEAT0 && r_wide) w_res_n[31:16] = bus.m_rdata;
            else                              w_res_n[15:0]  = bus.m_rdata;
          end
          w_state_n = (r_state == S_BEAT0 && r_wide) ? S_BEAT1 : S_RESP;
        end else begin
          w_wc_n = r_wc + 2'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Pins are registered, so they are derived from the state being entered.
  always_comb begin
    w_m_addr_n  = r_m_addr;
    w_m_wdata_n = r_m_wdata;
    w_m_mr_n    = 1'b0;
    w_m_mw_n    = 1'b0;
    w_d_done_n  = 1'b0;
    w_f_done_n  = 1'b0;
    w_d_rdata_n = r_d_rdata;
    w_f_rdata_n = r_f_rdata;
    case (w_state_n)
      S_BEAT0: begin
        w_m_addr_n  = w_addr_n;
        w_m_wdata_n = w_wide_n ? w_wdata_n[31:16] : w_wdata_n[15:0];
        w_m_mr_n    = ~w_we_n;
        w_m_mw_n    = w_we_n & (w_wc_n == c_wc_last);
      end
      S_BEAT1: begin
        w_m_addr_n  = w_addr_n + 32'd1;
        w_m_wdata_n = w_wdata_n[15:0];
        w_m_mr_n    = ~w_we_n;
        w_m_mw_n    = w_we_n & (w_wc_n == c_wc_last);
      end
      S_RESP: begin
        if (r_own_f) begin
          w_f_done_n  = 1'b1;
          w_f_rdata_n = w_res_n[15:0];
        end else begin
          w_d_done_n  = 1'b1;
          w_d_rdata_n = w_res_n;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wc      <= 2'd0;
      r_sc      <= 2'd0;
      r_own_f   <= 1'b0;
      r_we      <= 1'b0;
      r_wide    <= 1'b0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_res     <= 32'h0;
      r_m_addr  <= 32'h0;
      r_m_wdata <= 16'h0;
      r_m_mr    <= 1'b0;
      r_m_mw    <= 1'b0;
      r_d_done  <= 1'b0;
      r_f_done  <= 1'b0;
      r_d_rdata <= 32'h0;
      r_f_rdata <= 16'h0;
    end else begin
      r_state   <= w_state_n;
      r_wc      <= w_wc_n;
      r_sc      <= w_sc_n;
      r_own_f   <= w_own_f_n;
      r_we      <= w_we_n;
      r_wide    <= w_wide_n;
      r_addr    <= w_addr_n;
      r_wdata   <= w_wdata_n;
      r_res     <= w_res_n;
      r_m_addr  <= w_m_addr_n;
      r_m_wdata <= w_m_wdata_n;
      r_m_mr    <= w_m_mr_n;
      r_m_mw    <= w_m_mw_n;
      r_d_done  <= w_d_done_n;
      r_f_done  <= w_f_done_n;
      r_d_rdata <= w_d_rdata_n;
      r_f_rdata <= w_f_rdata_n;
    end
  end

  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.m_mr    = r_m_mr;
  assign bus.m_mw    = r_m_mw;
  assign bus.d_done  = r_d_done;
  assign bus.f_done  = r_f_done;
  assign bus.d_rdata = r_d_rdata;
  assign bus.f_rdata = r_f_rdata;
  assign bus.d_stall = bus.d_req & ~r_d_done;
  assign bus.f_stall = bus.f_req & ~r_f_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Directed scoreboard bench; unit 0 runs WAIT_CYCLES=1, unit 1 runs 2.
// Revision : 1.0
// ============================================================================
module tb_mem_access_ctrl;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    bit          chk_rd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        d_req, d_we, d_wide, f_req;
  logic [31:0] d_addr, d_wdata, f_addr;

  int n_cmp = 0;
  int n_mis = 0;
  int mw_cnt = 0;
  int both_cnt = 0;

  exp_t d_q[$];
  exp_t f_q[$];
  byte  g_q[$];

  logic [15:0] mem1 [logic [31:0]];
  logic [15:0] mem2 [logic [31:0]];

  mem_access_ctrl_if bus1 ();
  mem_access_ctrl_if bus2 ();

  mem_access_ctrl #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  mem_access_ctrl #(.WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign bus1.d_req   = d_req & ~sel;
  assign bus1.f_req   = f_req & ~sel;
  assign bus1.d_we    = d_we;
  assign bus1.d_wide  = d_wide;
  assign bus1.d_addr  = d_addr;
  assign bus1.d_wdata = d_wdata;
  assign bus1.f_addr  = f_addr;
  assign bus2.d_req   = d_req & sel;
  assign bus2.f_req   = f_req & sel;
  assign bus2.d_we    = d_we;
  assign bus2.d_wide  = d_wide;
  assign bus2.d_addr  = d_addr;
  assign bus2.d_wdata = d_wdata;
  assign bus2.f_addr  = f_addr;

  logic        w_d_done, w_f_done, w_d_stall, w_f_stall, w_m_mr, w_m_mw;
  logic [31:0] w_d_rdata, w_m_addr;
  logic [15:0] w_f_rdata, w_m_wdata;

  assign w_d_done  = sel ? bus2.d_done  : bus1.d_done;
  assign w_f_done  = sel ? bus2.f_done  : bus1.f_done;
  assign w_d_stall = sel ? bus2.d_stall : bus1.d_stall;
  assign w_f_stall = sel ? bus2.f_stall : bus1.f_stall;
  assign w_m_mr    = sel ? bus2.m_mr    : bus1.m_mr;
  assign w_m_mw    = sel ? bus2.m_mw    : bus1.m_mw;
  assign w_d_rdata = sel ? bus2.d_rdata : bus1.d_rdata;
  assign w_f_rdata = sel ? bus2.f_rdata : bus1.f_rdata;
  assign w_m_addr  = sel ? bus2.m_addr  : bus1.m_addr;
  assign w_m_wdata = sel ? bus2.m_wdata : bus1.m_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory arrays: write on a strobed cycle, present read data mid-cycle.
  always @(negedge clk) begin
    if (bus1.m_mw) mem1[bus1.m_addr] = bus1.m_wdata;
    if (bus2.m_mw) mem2[bus2.m_addr] = bus2.m_wdata;
    bus1.m_rdata = bus1.m_mr ? (mem1.exists(bus1.m_addr) ? mem1[bus1.m_addr] : 16'h0) : 16'hDEAD;
    bus2.m_rdata = bus2.m_mr ? (mem2.exists(bus2.m_addr) ? mem2[bus2.m_addr] : 16'h0) : 16'hDEAD;
    if (w_m_mw) mw_cnt++;
    if (w_m_mw && w_m_mr) both_cnt++;
  end

  function automatic logic [15:0] mem_at(input logic s, input logic [31:0] a);
    if (s) return mem2.exists(a) ? mem2[a] : 16'h0;
    return mem1.exists(a) ? mem1[a] : 16'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered #1 after a rising edge with the selected unit idle.
  task automatic d_access(input string tag, input logic we, input logic wide,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rd,
                          output int n_mw, output int mw_cyc, output logic [31:0] strobe_addr);
    exp_t e;
    bit   got;
    int   mw0;
    e.lat = exp_lat;
    e.rd = exp_rd;
    e.chk_rd = !we;
    d_q.push_back(e);
    mw0 = mw_cnt;
    mw_cyc = -1;
    strobe_addr = 32'h0;
    got = 1'b0;
    d_we = we; d_wide = wide; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (w_m_mw) mw_cyc = k;
      if (w_m_mr || w_m_mw) strobe_addr = w_m_addr;
      if (w_d_done) begin
        got = 1'b1;
        e = d_q.pop_front();
        check({tag, ":latency"}, k, e.lat);
        if (e.chk_rd) check({tag, ":d_rdata"}, w_d_rdata, e.rd);
        check({tag, ":strobes_in_resp"}, {w_m_mr, w_m_mw}, 32'h0);
      end
      @(posedge clk);
      #1;
    end
    d_req = 1'b0;
    check({tag, ":done_seen"}, got, 1);
    if (!got) e = d_q.pop_front();
    n_mw = mw_cnt - mw0;
  endtask

  initial begin
    int          n_mw, mw_cyc, mw0, first_f, ndone, sim_seen;
    logic [31:0] sa;
    exp_t        e;
    byte         obs_g;
    bit          drop_d, drop_f;

    rst = 1'b1; sel = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_wide = 1'b0; f_req = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; f_addr = 32'h0;
    repeat (2) @(negedge clk);
    check("reset:d_done", w_d_done, 0);
    check("reset:f_done", w_f_done, 0);
    check("reset:m_mr", w_m_mr, 0);
    check("reset:m_mw", w_m_mw, 0);
    check("reset:m_addr", w_m_addr, 0);
    check("reset:m_wdata", w_m_wdata, 0);
    check("reset:d_rdata", w_d_rdata, 0);
    check("reset:f_rdata", w_f_rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // W=1 narrow write then read
    d_access("nw", 1'b1, 1'b0, 32'h10, 32'h0000BEEF, 2, 32'h0, n_mw, mw_cyc, sa);
    check("nw:mw_count", n_mw, 1);
    check("nw:mw_cycle", mw_cyc, 1);
    check("nw:mw_addr", sa, 32'h10);
    check("nw:mem", mem_at(1'b0, 32'h10), 32'hBEEF);
    d_access("nr", 1'b0, 1'b0, 32'h10, 32'h0, 2, 32'h0000BEEF, n_mw, mw_cyc, sa);
    check("nr:mw_count", n_mw, 0);

    // W=1 wide write across the address wrap, then read it back
    d_access("ww", 1'b1, 1'b1, 32'hFFFFFFFF, 32'hA5A55A5A, 3, 32'h0, n_mw, mw_cyc, sa);
    check("ww:mw_count", n_mw, 2);
    check("ww:beat1_addr", sa, 32'h0);
    check("ww:mem_hi", mem_at(1'b0, 32'hFFFFFFFF), 32'hA5A5);
    check("ww:mem_lo", mem_at(1'b0, 32'h0), 32'h5A5A);
    d_access("wr", 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, 3, 32'hA5A55A5A, n_mw, mw_cyc, sa);
    check("wr:beat1_addr", sa, 32'h0);
    d_access("fpre", 1'b1, 1'b0, 32'h40, 32'h0000CAFE, 2, 32'h0, n_mw, mw_cyc, sa);

    // Simultaneous single requests: data first, fetch right after
    e.lat = 2; e.rd = 32'h0000BEEF; e.chk_rd = 1'b1; d_q.push_back(e);
    e.lat = 5; e.rd = 32'h0000CAFE; e.chk_rd = 1'b1; f_q.push_back(e);
    d_we = 1'b0; d_wide = 1'b0; d_addr = 32'h10; f_addr = 32'h40;
    d_req = 1'b1; f_req = 1'b1;
    sim_seen = 0;
    for (int k = 0; k < 30 && sim_seen < 2; k++) begin
      @(negedge clk);
      drop_d = 1'b0; drop_f = 1'b0;
      if (w_d_done) begin
        e = d_q.pop_front();
        check("sim:d_cycle", k, e.lat);
        check("sim:d_rdata", w_d_rdata, e.rd);
        drop_d = 1'b1; sim_seen++;
      end
      if (w_f_done) begin
        e = f_q.pop_front();
        check("sim:f_cycle", k, e.lat);
        check("sim:f_rdata", {16'h0, w_f_rdata}, e.rd);
        drop_f = 1'b1; sim_seen++;
      end
      @(posedge clk); #1;
      if (drop_d) d_req = 1'b0;
      if (drop_f) f_req = 1'b0;
    end
    d_req = 1'b0; f_req = 1'b0;
    check("sim:both_done", sim_seen, 2);

    // Starvation: both held high, fetch gets every fourth grant
    g_q = {"D", "D", "D", "F", "D", "D", "D", "F"};
    d_req = 1'b1; f_req = 1'b1;
    first_f = -1; ndone = 0;
    for (int k = 0; k < 60 && ndone < 8; k++) begin
      @(negedge clk);
      if (first_f < 0 && !w_f_done) check("starve:f_stall", w_f_stall, 1);
      if (w_d_done || w_f_done) begin
        obs_g = w_f_done ? "F" : "D";
        check("starve:grant", {w_d_done & w_f_done, obs_g}, {1'b0, g_q.pop_front()});
        if (w_d_done) check("starve:d_rdata", w_d_rdata, 32'h0000BEEF);
        if (w_f_done) begin
          check("starve:f_rdata", w_f_rdata, 32'hCAFE);
          check("starve:f_stall_at_done", w_f_stall, 0);
          if (first_f < 0) first_f = k;
        end
        ndone++;
      end
      @(posedge clk); #1;
    end
    d_req = 1'b0; f_req = 1'b0;
    check("starve:grants", ndone, 8);
    check("starve:first_f_cycle", first_f, 11);

    // W=2 wide write and read
    sel = 1'b1;
    @(posedge clk); #1;
    d_access("w2w", 1'b1, 1'b1, 32'h20, 32'h12345678, 5, 32'h0, n_mw, mw_cyc, sa);
    check("w2w:mw_count", n_mw, 2);
    check("w2w:mem_hi", mem_at(1'b1, 32'h20), 32'h1234);
    check("w2w:mem_lo", mem_at(1'b1, 32'h21), 32'h5678);
    d_access("w2r", 1'b0, 1'b1, 32'h20, 32'h0, 5, 32'h12345678, n_mw, mw_cyc, sa);
    check("w2r:beat1_addr", sa, 32'h21);
    d_access("w2pre", 1'b1, 1'b1, 32'h30, 32'h11112222, 5, 32'h0, n_mw, mw_cyc, sa);

    // Reset in the first wait cycle of a W=2 wide write
    mw0 = mw_cnt;
    d_we = 1'b1; d_wide = 1'b1; d_addr = 32'h30; d_wdata = 32'hAAAABBBB; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst:pre_strobe_mr", w_m_mr, 0);
    rst = 1'b1;
    #1;
    check("rst:m_mw", w_m_mw, 0);
    check("rst:m_addr", w_m_addr, 0);
    check("rst:m_wdata", w_m_wdata, 0);
    check("rst:d_rdata", w_d_rdata, 0);
    check("rst:d_done", w_d_done, 0);
    @(posedge clk); #1;
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst:no_done", w_d_done, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst:no_strobe", mw_cnt - mw0, 0);
    check("rst:mem_hi", mem_at(1'b1, 32'h30), 32'h1111);
    check("rst:mem_lo", mem_at(1'b1, 32'h31), 32'h2222);
    d_access("rst_fresh", 1'b0, 1'b0, 32'h20, 32'h0, 3, 32'h00001234, n_mw, mw_cyc, sa);

    check("mr_mw_exclusive", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
